instr_fetch_ctrl: RTL

- Sequences the 16-bit instruction memory: owns the program counter (PC), drives the memory address, and captures the combinational instruction word.
- Queues fetched {pc, instruction} pairs in a small skid FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects, halt/resume, and out-of-range fetch faults.
- Sits between the instruction memory and the decode stage of the RISC core.

---
 rtl/risc16_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// Shared types and constants for the RISC16 front end: PC/instruction widths,
// fetch FSM states and the {pc, instr} entry carried from fetch to decode.
package risc16_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are halfword aligned, so bit 0 of any target is dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(1);
  endfunction

  function automatic logic pc_in_imem(input logic [PC_W-1:0] addr, input int depth);
    return 32'(addr >> 1) < depth;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries between fetch and decode.
// Flush wins over push and pop; a push is accepted when full only alongside a pop.
module fetch_fifo
  import risc16_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  fetch_entry_t     mem [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, fetches from the 16-bit imem and
// queues {pc, instr} for decode. Optional perf counters: FETCH_PERF_CNT_EN.
module instr_fetch_ctrl
  import risc16_pkg::*;
#(
  parameter int              IMEM_DEPTH = 15,
  parameter int              BUF_DEPTH  = 2,
  parameter logic [PC_W-1:0] RESET_PC   = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  input  logic               resume,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               fault,
`ifdef FETCH_PERF_CNT_EN
  output logic               busy,
  output logic [31:0]        perf_fetch,
  output logic [31:0]        perf_stall
`else
  output logic               busy
`endif
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            fault_q;
  logic            busy_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            push;
  logic            flush;
  logic            pc_ok;
  logic            target_ok;
  logic [PC_W-1:0] target;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign target     = align_pc(redirect_pc);
  assign pc_ok      = pc_in_imem(pc, IMEM_DEPTH);
  assign target_ok  = pc_in_imem(target, IMEM_DEPTH);
  assign flush      = redirect_valid && (state != IDLE);
  assign pop        = out_valid && out_ready;
  assign push       = (state == RUN) && !redirect_valid && !halt && pc_ok &&
                      (!fifo_full || pop);
  assign push_entry = '{pc: pc, instr: imem_instr};

  assign imem_pc   = pc;
  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign fault     = fault_q;
  assign busy      = busy_q;

  // Redirect outranks halt, resume and fault detection in every non-IDLE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= RUN;
          busy_q <= 1'b1;
        end
        RUN: begin
          if (redirect_valid) begin
            pc <= target;
          end else if (halt) begin
            state  <= HALTED;
            busy_q <= 1'b0;
          end else if (!pc_ok) begin
            state   <= FAULT;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
          end else if (push) begin
            pc <= pc + PC_W'(2);
          end
        end
        HALTED: begin
          if (redirect_valid) begin
            pc <= target;
          end else if (resume && !halt) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        FAULT: begin
          if (redirect_valid) begin
            pc <= target;
            if (target_ok) begin
              state   <= RUN;
              fault_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          fault_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters: pushes, and RUN cycles blocked by a full, undrained FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (push && (perf_fetch != '1)) begin
        perf_fetch <= perf_fetch + 32'd1;
      end
      if ((state == RUN) && fifo_full && !pop && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
